// File: rtl/fixed_act_requantize_pkg.sv
// Shared fixed-point constants for activation-layer requantization:
// the rounding shift amount and the clamp limits of a signed output word.
package fixed_act_requantize_pkg;

    function automatic int calc_shift(input int in_frac, input int out_frac);
        return in_frac - out_frac;
    endfunction

    function automatic int out_max_val(input int out_w);
        return (1 <<< (out_w - 1)) - 1;
    endfunction

    function automatic int out_min_val(input int out_w);
        return -(1 <<< (out_w - 1));
    endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// One lane of requantization: round-half-up shift (first half) and
// clamp-with-flag (second half); the pipeline register sits between them.
module fixed_round_sat
    import fixed_act_requantize_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 4
) (
    input  logic [IN_W-1:0]  i_data,
    output logic [IN_W:0]    o_rounded,
    input  logic [IN_W:0]    i_rounded,
    output logic [OUT_W-1:0] o_data,
    output logic             o_sat
);
    localparam int RW = IN_W + 1;
    localparam logic signed [RW-1:0] MAX_V = RW'(out_max_val(OUT_W));
    localparam logic signed [RW-1:0] MIN_V = RW'(out_min_val(OUT_W));

    // One extra sign bit keeps the +half addition from overflowing.
    logic signed [RW-1:0] w_ext;
    logic signed [RW-1:0] w_r;

    assign w_ext = signed'({i_data[IN_W-1], i_data});
    assign w_r   = signed'(i_rounded);

    generate
        if (SHIFT == 0) begin : g_bypass
            assign o_rounded = w_ext;
        end else begin : g_round
            localparam logic signed [RW-1:0] HALF = RW'(2 ** (SHIFT - 1));
            logic signed [RW-1:0] w_sum;
            assign w_sum     = w_ext + HALF;
            assign o_rounded = w_sum >>> SHIFT;
        end
    endgenerate

    always_comb begin
        o_sat  = 1'b0;
        o_data = w_r[OUT_W-1:0];
        if (w_r > MAX_V) begin
            o_data = MAX_V[OUT_W-1:0];
            o_sat  = 1'b1;
        end else if (w_r < MIN_V) begin
            o_data = MIN_V[OUT_W-1:0];
            o_sat  = 1'b1;
        end
    end

endmodule

// File: rtl/fixed_act_requantize.sv
// Two-stage valid/ready requantizer: stage 1 holds rounded lanes, stage 2
// holds clamped lanes plus saturation and end-of-tensor flags.
module fixed_act_requantize
    import fixed_act_requantize_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0       = 16,
    parameter int DATA_IN_0_PRECISION_1       = 8,
    parameter int DATA_OUT_0_PRECISION_0      = 8,
    parameter int DATA_OUT_0_PRECISION_1      = 4,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready,
    output logic                              data_out_0_last,
    output logic                              data_out_0_sat
);
    localparam int P     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int IN_W  = DATA_IN_0_PRECISION_0;
    localparam int OUT_W = DATA_OUT_0_PRECISION_0;
    localparam int RW    = IN_W + 1;
    localparam int SHIFT = calc_shift(DATA_IN_0_PRECISION_1, DATA_OUT_0_PRECISION_1);
    localparam int BEATS = (DATA_IN_0_TENSOR_SIZE_DIM_0 / DATA_IN_0_PARALLELISM_DIM_0)
                         * (DATA_IN_0_TENSOR_SIZE_DIM_1 / DATA_IN_0_PARALLELISM_DIM_1);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if (SHIFT < 0) begin : g_shift_check
            $error("fixed_act_requantize: output fractional bits exceed input fractional bits");
        end
    endgenerate

    logic [RW-1:0]    w_rounded  [P];
    logic [OUT_W-1:0] w_sat_data [P];
    logic [P-1:0]     w_lane_sat;
    logic             w_s1_adv;
    logic             w_s2_adv;
    logic             w_accept;
    logic             w_in_last;

    logic [RW-1:0]    r_s1_data [P];
    logic             r_s1_valid;
    logic             r_s1_last;
    logic [OUT_W-1:0] r_s2_data [P];
    logic             r_s2_valid;
    logic             r_s2_last;
    logic             r_s2_sat;
    logic [CNT_W-1:0] r_beat_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_lane
            fixed_round_sat #(
                .IN_W  (IN_W),
                .OUT_W (OUT_W),
                .SHIFT (SHIFT)
            ) u_round_sat (
                .i_data    (data_in_0[gi]),
                .o_rounded (w_rounded[gi]),
                .i_rounded (r_s1_data[gi]),
                .o_data    (w_sat_data[gi]),
                .o_sat     (w_lane_sat[gi])
            );
            assign data_out_0[gi] = r_s2_data[gi];
        end
    endgenerate

    // Each stage moves when it is empty or the stage after it is taking its beat.
    assign w_s2_adv        = !r_s2_valid || data_out_0_ready;
    assign w_s1_adv        = !r_s1_valid || w_s2_adv;
    assign data_in_0_ready = rst && w_s1_adv;
    assign w_accept        = data_in_0_valid && data_in_0_ready;
    assign w_in_last       = (r_beat_cnt == CNT_W'(BEATS - 1));

    assign data_out_0_valid = r_s2_valid;
    assign data_out_0_last  = r_s2_last;
    assign data_out_0_sat   = r_s2_sat;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_sat   <= 1'b0;
            r_beat_cnt <= '0;
            for (int i = 0; i < P; i++) begin
                r_s1_data[i] <= '0;
                r_s2_data[i] <= '0;
            end
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= w_accept;
                r_s1_last  <= w_accept && w_in_last;
                for (int i = 0; i < P; i++) begin
                    r_s1_data[i] <= w_rounded[i];
                end
            end
            if (w_accept) begin
                r_beat_cnt <= w_in_last ? '0 : r_beat_cnt + 1'b1;
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                r_s2_last  <= r_s1_valid && r_s1_last;
                r_s2_sat   <= r_s1_valid && (|w_lane_sat);
                for (int i = 0; i < P; i++) begin
                    r_s2_data[i] <= w_sat_data[i];
                end
            end
        end
    end

endmodule
